comp_clk_array: RTL

COMP_CLK_ARRAY -- requirements
Module: comp_clk_array

---
 rtl/comp_clk_array.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/comp_clk_array.sv
// comp_clk_array: N_CH-channel clocked comparator array.
// Stage 1 subtracts a per-channel offset at W+1 bits, so the difference
// never wraps. Stage 2 applies a shared hysteresis window, then a
// per-channel debounce of DEB agreeing samples. Each channel also keeps a
// saturating count of its output transitions.
module comp_clk_array #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int DEB  = 2,
  parameter int CW   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N_CH*W-1:0]   in_data,
  input  logic [N_CH*W-1:0]   offset,
  input  logic [W-2:0]        hyst,
  input  logic                cnt_clr,
  output logic                out_valid,
  output logic [N_CH-1:0]     out,
  output logic [N_CH*CW-1:0]  toggle_cnt
);

  // The agree counter holds 0..DEB-1. It needs at least one bit even when DEB=1.
  localparam int AW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [AW-1:0] AGREE_LAST = AW'(DEB - 1);
  localparam logic [AW-1:0] AGREE_ONE  = AW'(1);
  localparam logic [AW-1:0] AGREE_ZERO = {AW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

  // Stage-1 registers.
  logic signed [W:0] d_r [N_CH];
  logic              v1_r;

  // Stage-2 registers and the output valid flag.
  logic [N_CH-1:0]   raw_r;
  logic [N_CH-1:0]   out_r;
  logic [AW-1:0]     agree_r [N_CH];
  logic              ov_r;
  logic [CW-1:0]     cnt_r [N_CH];

  // Stage-2 next-state values.
  logic [N_CH-1:0]   raw_nxt_s;
  logic [N_CH-1:0]   out_nxt_s;
  logic [AW-1:0]     agree_nxt_s [N_CH];
  logic [N_CH-1:0]   toggle_s;
  logic signed [W:0] hyst_pos_s;
  logic signed [W:0] hyst_neg_s;

  // Stage 1: sign-extend both operands to W+1 bits so that d never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        d_r[k] <= {(W+1){1'b0}};
      end
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < N_CH; k++) begin
          d_r[k] <= $signed({in_data[k*W+W-1], in_data[k*W +: W]})
                  - $signed({offset[k*W+W-1], offset[k*W +: W]});
        end
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          d_r[k] <= d_r[k];
        end
      end
    end
  end

  // Stage-2 combinational update: hysteresis slicer, then the debounce counter.
  always_comb begin
    hyst_pos_s = $signed({2'b00, hyst});
    hyst_neg_s = -hyst_pos_s;
    raw_nxt_s  = raw_r;
    out_nxt_s  = out_r;
    for (int k = 0; k < N_CH; k++) begin
      agree_nxt_s[k] = agree_r[k];
    end
    if (v1_r) begin
      for (int k = 0; k < N_CH; k++) begin
        // Strict compares: d exactly at the threshold does not cross it.
        if (!raw_r[k] && (d_r[k] > hyst_pos_s)) begin
          raw_nxt_s[k] = 1'b1;
        end else if (raw_r[k] && (d_r[k] < hyst_neg_s)) begin
          raw_nxt_s[k] = 1'b0;
        end else begin
          raw_nxt_s[k] = raw_r[k];
        end
        // A sample that agrees with out clears the count. A run of DEB disagreeing samples flips out.
        if (raw_nxt_s[k] == out_r[k]) begin
          agree_nxt_s[k] = AGREE_ZERO;
        end else if (agree_r[k] == AGREE_LAST) begin
          out_nxt_s[k]   = raw_nxt_s[k];
          agree_nxt_s[k] = AGREE_ZERO;
        end else begin
          agree_nxt_s[k] = agree_r[k] + AGREE_ONE;
        end
      end
    end else begin
      raw_nxt_s = raw_r;
      out_nxt_s = out_r;
    end
    toggle_s = out_nxt_s ^ out_r;
  end

  // Stage-2 registers: they change only on valid samples, and reset clears any sample in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_r <= {N_CH{1'b0}};
      out_r <= {N_CH{1'b0}};
      ov_r  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        agree_r[k] <= AGREE_ZERO;
      end
    end else begin
      raw_r <= raw_nxt_s;
      out_r <= out_nxt_s;
      ov_r  <= v1_r;
      for (int k = 0; k < N_CH; k++) begin
        agree_r[k] <= agree_nxt_s[k];
      end
    end
  end

  // Toggle counters: they saturate instead of wrapping, and a clear drops any toggle in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
    end else if (cnt_clr) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_r[k] <= CNT_ZERO;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (toggle_s[k] && (cnt_r[k] != CNT_MAX)) begin
          cnt_r[k] <= cnt_r[k] + CNT_ONE;
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  // Output packing. Every output comes straight from a register.
  always_comb begin
    out_valid  = ov_r;
    out        = out_r;
    toggle_cnt = {(N_CH*CW){1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      toggle_cnt[k*CW +: CW] = cnt_r[k];
    end
  end

endmodule
